// File: rtl/master_tg_pkg.sv
// Shared types and constants for the traffic-generating bus master.
// State encoding, LFSR polynomial, command encoding and a constant log2 helper.
package master_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } tg_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Stops at bit 30 so the shifted probe never goes negative.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tg_lfsr.sv
// Right-shifting Galois LFSR; steps once per cycle with adv_i high, holds otherwise.
// Zero latency: state_o is the current register, the step is visible next cycle.
module tg_lfsr #(
  parameter int           W    = 32,
  parameter logic [W-1:0] TAPS = 32'h8020_0003,
  parameter logic [W-1:0] SEED = 32'hACE1_2025
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         adv_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= SEED;
    else if (adv_i) lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/master_traffic_gen.sv
// Pseudo-random read/write bus master with local word memory, idle gaps, budget and ack watchdog.
// Request fields are registered at launch and held until m_ack; reads finish one cycle after the ack.
module master_traffic_gen
  import master_tg_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          MEM_DEPTH = 32,
  parameter int          SLV_BITS  = 1,
  parameter int          WR_THRESH = 128,
  parameter int          IDLE_MAX  = 3,
  parameter int          NUM_TXN   = 0,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] SEED      = 32'hACE1_2025
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_cmd,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       txn_cnt
);

  localparam int IDX_W = clog2(MEM_DEPTH);
  // A one-bit gap counter masked to zero stands in for IDLE_MAX = 0.
  localparam int GAP_W = (IDLE_MAX > 0) ? clog2(IDLE_MAX + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MASK = GAP_W'(IDLE_MAX);
  localparam logic [GAP_W-1:0] GAP_RST  = SEED[16 +: GAP_W] & GAP_MASK;

  tg_state_e         state_q;
  logic [GAP_W-1:0]  gap_q;
  logic [31:0]       wait_q;
  logic              m_req_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic              m_cmd_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       txn_cnt_q;
  logic [31:0]       txn_cnt_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [31:0]       lfsr;
  logic              launch;
  logic              launch_cmd;
  logic [IDX_W-1:0]  launch_idx;
  logic [ADDR_W-1:0] launch_addr;
  logic [GAP_W-1:0]  gap_load;
  logic              budget_hit;
  logic              unused_lfsr;

  assign launch = (state_q == ST_IDLE) && !done_q && start && (gap_q == '0);

  tg_lfsr #(
    .W    (32),
    .TAPS (LFSR_TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .resetn  (resetn),
    .adv_i   (launch),
    .state_o (lfsr)
  );

  always_comb begin
    launch_cmd  = ({1'b0, lfsr[7:0]} < 9'(WR_THRESH));
    launch_idx  = lfsr[8 +: IDX_W];
    launch_addr = '0;
    launch_addr[IDX_W-1:0] = launch_idx;
    launch_addr[ADDR_W-1 -: SLV_BITS] = lfsr[31 -: SLV_BITS];
    gap_load    = lfsr[16 +: GAP_W] & GAP_MASK;
    txn_cnt_d   = txn_cnt_q + 32'd1;
    budget_hit  = (NUM_TXN != 0) && (txn_cnt_d == 32'(NUM_TXN));
  end

  assign unused_lfsr = ^lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      gap_q     <= GAP_RST;
      wait_q    <= '0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_cmd_q   <= CMD_RD;
      m_wdata_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      txn_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (done_q) begin
            state_q <= ST_DONE;
          end else if (start) begin
            if (gap_q == '0) begin
              m_req_q   <= 1'b1;
              m_addr_q  <= launch_addr;
              m_cmd_q   <= launch_cmd;
              m_wdata_q <= launch_cmd ? mem_q[launch_idx] : '0;
              wait_q    <= '0;
              state_q   <= ST_REQ;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            if (m_cmd_q == CMD_WR) begin
              txn_cnt_q <= txn_cnt_d;
              done_q    <= budget_hit;
              gap_q     <= gap_load;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_RDATA;
            end
          end else if (wait_q == 32'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            m_req_q <= 1'b0;
            gap_q   <= gap_load;
            state_q <= ST_IDLE;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        ST_RDATA: begin
          txn_cnt_q <= txn_cnt_d;
          done_q    <= budget_hit;
          gap_q     <= gap_load;
          state_q   <= ST_IDLE;
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset forces state_q out of RDATA, so in-flight read data never lands.
  always_ff @(posedge clk) begin
    if (state_q == ST_RDATA) mem_q[m_addr_q[IDX_W-1:0]] <= m_rdata;
  end

  assign m_req   = m_req_q;
  assign m_addr  = m_addr_q;
  assign m_cmd   = m_cmd_q;
  assign m_wdata = m_wdata_q;
  assign done    = done_q;
  assign err     = err_q;
  assign txn_cnt = txn_cnt_q;

endmodule

// File: doc/master_traffic_gen.md
Name: master_traffic_gen

Overview:
- Parametrised, synthesizable traffic-generating bus master for crossbar verification.
- Issues pseudo-random read/write requests over the req/addr/cmd/wdata, ack/rdata handshake toward one crossbar master port.
- Sources write data from, and stores read data into, a local word memory.
- Adds LFSR-based randomisation, a configurable write ratio, random idle gaps, a transaction budget, an ack watchdog and status outputs.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- MEM_DEPTH, 32, local memory words; must be a power of 2; IDX_W = log2(MEM_DEPTH).
- SLV_BITS, 1, number of MSB address bits that select the slave.
- WR_THRESH, 128, write issued when LFSR byte [7:0] < WR_THRESH (0 = reads only, 256 = writes only).
- IDLE_MAX, 3, maximum random idle cycles between transactions; must be a power of 2 minus 1.
- NUM_TXN, 0, transactions to issue before done; 0 = unlimited.
- TIMEOUT, 255, maximum cycles to wait for ack before flagging an error.
- SEED, 32'hACE1_2025, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  level enable; generator runs while high.
- m_req  out  1  request valid.
- m_addr  out  ADDR_W  request address.
- m_cmd  out  1  1 = write, 0 = read.
- m_wdata  out  DATA_W  write data; 0 when m_cmd = 0.
- m_ack  in  1  request accepted by the crossbar.
- m_rdata  in  DATA_W  read data, valid the cycle after the ack of a read.
- done  out  1  NUM_TXN budget exhausted.
- err  out  1  sticky; set on ack timeout.
- txn_cnt  out  32  completed transactions.

Behaviour:
- Reset values: m_req=0, m_addr=0, m_cmd=0, m_wdata=0, done=0, err=0, txn_cnt=0, LFSR=SEED, state=IDLE. Local memory is not reset; it is preloaded by the bench.
- LFSR: 32-bit Galois, taps 0x80200003. Advances one step each time a request is launched, and only then.
- Request fields at launch:
  - m_cmd = (lfsr[7:0] < WR_THRESH).
  - m_addr[ADDR_W-1 -: SLV_BITS] = lfsr[31 -: SLV_BITS].
  - m_addr[IDX_W-1:0] = lfsr[8 +: IDX_W].
  - All other address bits = 0.
  - m_wdata = mem[idx], registered at launch.
- States:
  - IDLE: gap counter loaded with lfsr[16 +: log2(IDLE_MAX+1)]. Counts down while start=1; at 0 go to REQ, driving the launch values on m_req=1 in the same cycle. Stay in IDLE while start=0. If done=1, go to DONE.
  - REQ: m_req, m_addr, m_cmd, m_wdata held stable until a cycle with m_ack=1. No change is allowed while waiting.
    - Write acked: txn_cnt+1, go to IDLE.
    - Read acked: go to RDATA.
    - Wait counter reaches TIMEOUT without ack: err=1, m_req drops, go to IDLE; txn_cnt is not incremented.
  - RDATA: m_req=0. mem[addr idx] <= m_rdata, txn_cnt+1, go to IDLE.
  - DONE: m_req=0, done=1. Leaves DONE only on reset.
- m_req deasserts in the cycle after ack. Back-to-back requests are impossible: minimum one idle cycle after a write, two after a read.
- Budget: done is set when txn_cnt reaches NUM_TXN, with NUM_TXN != 0.
- start low while in REQ or RDATA: the outstanding transaction completes, then the generator parks in IDLE.
- m_ack while m_req=0: ignored.
- Async reset mid-transaction: all outputs return to reset values immediately; the pending read data is discarded.
- txn_cnt wraps at 2^32 without affecting other behaviour.

Decomposition:
- Package master_tg_pkg holds:
  - state encoding (IDLE, REQ, RDATA, DONE);
  - LFSR tap constant;
  - CMD_RD / CMD_WR constants;
  - clog2 helper function.
- One sub-module, tg_lfsr: parametrised width, taps and seed; advance enable input; state output.

Test Plan:
1. WR_THRESH=256, IDLE_MAX=0, ack returned 1 cycle after req, NUM_TXN=4 -> four writes with m_wdata equal to the preloaded mem[idx]; txn_cnt=4; done=1; m_req=0 thereafter.
2. WR_THRESH=0, slave returns m_rdata=32'hDEAD0000+idx the cycle after ack -> mem[idx] holds that value after each read; txn_cnt increments in the RDATA cycle.
3. Ack withheld 5 cycles -> m_addr, m_cmd and m_wdata constant over all 6 req cycles; m_req low the cycle after ack.
4. TIMEOUT=8, ack never asserted -> err=1 after 8 waiting cycles; m_req=0; txn_cnt unchanged; generator relaunches.
5. start dropped during a pending read -> the read completes and memory is updated, then no new m_req until start=1.
6. Two runs with the same SEED -> identical address/cmd sequences. resetn pulsed mid-request -> m_req=0 asynchronously and the sequence restarts from SEED.
